// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 8-bit CPU: owns PC and IR, arbitrates the
// shared memory port between instruction fetch and LD/ST, and strobes register writes.
module cpu_sequencer #(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic [PC_W-1:0]  pc,
  input  logic [7:0]       mem_rdata,
  input  logic             mem_ready,
  output logic [7:0]       ir,
  input  logic [4:0]       opcode,
  input  logic             is_mem_op,
  input  logic             mem_rw,
  input  logic             increment_pc,
  output logic             reg_we,
  output logic             reg_src,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);

  // Memory handshake: mem_req is held in FETCH/MEM until mem_ready is seen high in the
  // same cycle; that cycle completes the access and nothing else is needed from memory.
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    HALT   = 3'd4
  } state_e;

  localparam logic [4:0] OP_HALT = 5'b11111;
  localparam logic [4:0] OP_LI   = 5'b00001;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e              state_q;
  logic [PC_W-1:0]     pc_q;
  logic [7:0]          ir_q;
  logic [CNT_W-1:0]    instret_q;
  logic                fault_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                timeout_hit;

  // The last waiting cycle before the limit faults unless mem_ready arrives in it.
  assign timeout_hit = (TIMEOUT > 0) && (wait_q == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      instret_q <= '0;
      fault_q   <= 1'b0;
      wait_q    <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata;
            state_q <= DECODE;
          end else if (timeout_hit) begin
            fault_q <= 1'b1;
            state_q <= HALT;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        DECODE: begin
          if (opcode == OP_HALT) begin
            state_q <= HALT;
          end else if (is_mem_op) begin
            wait_q  <= '0;
            state_q <= MEM;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (increment_pc) pc_q <= pc_q + PC_W'(1);
          instret_q <= instret_q + CNT_W'(1);
          wait_q    <= '0;
          state_q   <= FETCH;
        end
        MEM: begin
          if (mem_ready) begin
            pc_q      <= pc_q + PC_W'(1);
            instret_q <= instret_q + CNT_W'(1);
            wait_q    <= '0;
            state_q   <= FETCH;
          end else if (timeout_hit) begin
            fault_q <= 1'b1;
            state_q <= HALT;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= HALT;
      endcase
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    reg_we       = 1'b0;
    reg_src      = 1'b0;
    case (state_q)
      FETCH: mem_req = 1'b1;
      EXEC:  reg_we  = (opcode == OP_LI) || opcode[4];
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = mem_rw;
        reg_we       = mem_ready && !mem_rw;
        reg_src      = mem_ready && !mem_rw;
      end
      default: ;
    endcase
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign instret = instret_q;
  assign state   = state_q;
  assign halted  = (state_q == HALT);
  assign fault   = fault_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: small instruction memory plus decoder model around
// the DUT, one task per scenario with hand-computed expectations.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_addr_sel;
  logic [7:0]  pc;
  logic [7:0]  mem_rdata;
  logic        mem_ready = 1'b1;
  logic [7:0]  ir;
  logic [4:0]  opcode;
  logic        is_mem_op, mem_rw, increment_pc;
  logic        reg_we, reg_src;
  logic [2:0]  state;
  logic        halted, fault;
  logic [15:0] instret;

  logic [7:0]  imem [0:255];
  logic [7:0]  ld_data = 8'hA5;
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  // Decoder: LD = 00010, ST = 00011, everything else is a non-memory op.
  assign opcode       = ir[7:3];
  assign is_mem_op    = (opcode == 5'b00010) || (opcode == 5'b00011);
  assign mem_rw       = (opcode == 5'b00011);
  assign increment_pc = !is_mem_op;
  assign mem_rdata    = mem_addr_sel ? ld_data : imem[pc];

  cpu_sequencer #(.PC_W(8), .TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .pc(pc), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ir(ir), .opcode(opcode), .is_mem_op(is_mem_op), .mem_rw(mem_rw),
    .increment_pc(increment_pc), .reg_we(reg_we), .reg_src(reg_src), .state(state),
    .halted(halted), .fault(fault), .instret(instret)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    imem[0] = 8'h0D; imem[4] = 8'h11; imem[5] = 8'h19;
    mem_ready = 1'b1;
    do_reset();
    #1;
    tests_run++;
    if ({state, pc, ir, instret, halted, fault} !== {3'd0, 8'd0, 8'd0, 16'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_values: state=%0d pc=%0h ir=%0h instret=%0d halted=%b fault=%b, want 0s",
               state, pc, ir, instret, halted, fault);
    end
  endtask

  task automatic test_li();
    tests_run++;
    if ({mem_req, mem_we, mem_addr_sel} !== 3'b100) begin
      tests_failed++; $display("FAIL li_fetch_strobes: got %b want 100", {mem_req, mem_we, mem_addr_sel});
    end
    step(); #1;
    tests_run++;
    if ({state, ir, mem_req} !== {3'd1, 8'h0D, 1'b0}) begin
      tests_failed++; $display("FAIL li_decode: state=%0d ir=%0h req=%b want 1/0d/0", state, ir, mem_req);
    end
    step(); #1;
    tests_run++;
    if ({state, reg_we, reg_src, mem_req} !== {3'd2, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL li_exec: state=%0d we=%b src=%b req=%b want 2/1/0/0", state, reg_we, reg_src, mem_req);
    end
    step(); #1;
    tests_run++;
    if ({state, pc, instret} !== {3'd0, 8'd1, 16'd1}) begin
      tests_failed++; $display("FAIL li_retire: state=%0d pc=%0d instret=%0d want 0/1/1", state, pc, instret);
    end
    repeat (9) step();
    tests_run++;
    if ({state, pc, instret} !== {3'd0, 8'd4, 16'd4}) begin
      tests_failed++; $display("FAIL nop_run: state=%0d pc=%0d instret=%0d want 0/4/4", state, pc, instret);
    end
  endtask

  task automatic test_ld();
    step();
    mem_ready = 1'b0;
    #1;
    tests_run++;
    if ({state, ir} !== {3'd1, 8'h11}) begin
      tests_failed++; $display("FAIL ld_decode: state=%0d ir=%0h want 1/11", state, ir);
    end
    for (int w = 0; w < 2; w++) begin
      step(); #1;
      tests_run++;
      if ({state, mem_req, mem_addr_sel, mem_we, reg_we, reg_src} !== {3'd3, 5'b11000}) begin
        tests_failed++; $display("FAIL ld_wait%0d: state=%0d strobes=%b want 3/11000", w, state,
                                 {mem_req, mem_addr_sel, mem_we, reg_we, reg_src});
      end
    end
    step();
    mem_ready = 1'b1;
    #1;
    tests_run++;
    if ({state, mem_req, mem_addr_sel, mem_we, reg_we, reg_src} !== {3'd3, 5'b11011}) begin
      tests_failed++; $display("FAIL ld_ready: state=%0d strobes=%b want 3/11011", state,
                               {mem_req, mem_addr_sel, mem_we, reg_we, reg_src});
    end
    step(); #1;
    tests_run++;
    if ({state, pc, instret, reg_we} !== {3'd0, 8'd5, 16'd5, 1'b0}) begin
      tests_failed++; $display("FAIL ld_retire: state=%0d pc=%0d instret=%0d we=%b want 0/5/5/0", state, pc, instret, reg_we);
    end
  endtask

  task automatic test_st();
    step();
    mem_ready = 1'b0;
    step(); #1;
    tests_run++;
    if ({state, mem_req, mem_addr_sel, mem_we, reg_we} !== {3'd3, 4'b1110}) begin
      tests_failed++; $display("FAIL st_wait: state=%0d strobes=%b want 3/1110", state, {mem_req, mem_addr_sel, mem_we, reg_we});
    end
    mem_ready = 1'b1;
    #1;
    tests_run++;
    if ({mem_we, reg_we, reg_src} !== 3'b100) begin
      tests_failed++; $display("FAIL st_ready: we/reg_we/src=%b want 100", {mem_we, reg_we, reg_src});
    end
    step(); #1;
    tests_run++;
    if ({state, pc, instret} !== {3'd0, 8'd6, 16'd6}) begin
      tests_failed++; $display("FAIL st_retire: state=%0d pc=%0d instret=%0d want 0/6/6", state, pc, instret);
    end
  endtask

  task automatic test_timeout();
    mem_ready = 1'b0;
    repeat (3) step();
    mem_ready = 1'b1;
    #1;
    tests_run++;
    if ({state, fault, mem_req} !== {3'd0, 1'b0, 1'b1}) begin
      tests_failed++; $display("FAIL to_ok_last_wait: state=%0d fault=%b req=%b want 0/0/1", state, fault, mem_req);
    end
    step(); #1;
    tests_run++;
    if ({state, fault, ir} !== {3'd1, 1'b0, 8'h00}) begin
      tests_failed++; $display("FAIL to_ok_decode: state=%0d fault=%b ir=%0h want 1/0/00", state, fault, ir);
    end
    step(); step(); #1;
    tests_run++;
    if ({state, pc, instret} !== {3'd0, 8'd7, 16'd7}) begin
      tests_failed++; $display("FAIL to_ok_retire: state=%0d pc=%0d instret=%0d want 0/7/7", state, pc, instret);
    end
    mem_ready = 1'b0;
    repeat (3) step();
    tests_run++;
    if ({state, fault, halted} !== {3'd0, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL to_fault_4th_wait: state=%0d fault=%b halted=%b want 0/0/0", state, fault, halted);
    end
    step();
    tests_run++;
    if ({state, fault, halted, mem_req, pc, instret} !== {3'd4, 1'b1, 1'b1, 1'b0, 8'd7, 16'd7}) begin
      tests_failed++; $display("FAIL to_fault: state=%0d fault=%b halted=%b req=%b pc=%0d instret=%0d want 4/1/1/0/7/7",
                               state, fault, halted, mem_req, pc, instret);
    end
    mem_ready = 1'b1;
    repeat (3) step();
    tests_run++;
    if ({state, mem_req, fault} !== {3'd4, 1'b0, 1'b1}) begin
      tests_failed++; $display("FAIL to_fault_sticky: state=%0d req=%b fault=%b want 4/0/1", state, mem_req, fault);
    end
  endtask

  task automatic test_wrap_halt();
    int n;
    imem[0] = 8'h00; imem[4] = 8'h00; imem[5] = 8'h00;
    mem_ready = 1'b1;
    do_reset();
    tests_run++;
    if ({fault, halted, state} !== {1'b0, 1'b0, 3'd0}) begin
      tests_failed++; $display("FAIL wrap_reset_clears_fault: fault=%b halted=%b state=%0d want 0/0/0", fault, halted, state);
    end
    step();
    imem[0] = 8'hF8;
    n = 0;
    while (!(state == 3'd0 && pc == 8'd255) && n < 1000) begin
      step();
      n++;
    end
    tests_run++;
    if (n >= 1000 || instret !== 16'd255) begin
      tests_failed++; $display("FAIL wrap_reach_255: cycles=%0d pc=%0d instret=%0d want pc 255 instret 255", n, pc, instret);
    end
    step(); step(); #1;
    tests_run++;
    if ({state, reg_we} !== {3'd2, 1'b0}) begin
      tests_failed++; $display("FAIL nop_exec: state=%0d reg_we=%b want 2/0", state, reg_we);
    end
    step();
    tests_run++;
    if ({state, pc, instret} !== {3'd0, 8'd0, 16'h0100}) begin
      tests_failed++; $display("FAIL pc_wrap: state=%0d pc=%0d instret=%0d want 0/0/256", state, pc, instret);
    end
    step(); step(); #1;
    tests_run++;
    if ({state, halted, fault, mem_req, pc, instret, ir} !== {3'd4, 1'b1, 1'b0, 1'b0, 8'd0, 16'h0100, 8'hF8}) begin
      tests_failed++; $display("FAIL halt_instr: state=%0d halted=%b fault=%b req=%b pc=%0d instret=%0d ir=%0h want 4/1/0/0/0/256/f8",
                               state, halted, fault, mem_req, pc, instret, ir);
    end
    repeat (4) step();
    tests_run++;
    if ({state, mem_req, pc, instret} !== {3'd4, 1'b0, 8'd0, 16'h0100}) begin
      tests_failed++; $display("FAIL halt_sticky: state=%0d req=%b pc=%0d instret=%0d want 4/0/0/256", state, mem_req, pc, instret);
    end
  endtask

  task automatic test_reset_mid();
    imem[0] = 8'h0D; imem[1] = 8'h11;
    mem_ready = 1'b1;
    do_reset();
    repeat (3) step();
    step();
    mem_ready = 1'b0;
    step(); step(); #1;
    tests_run++;
    if ({state, mem_addr_sel, pc, instret, ir} !== {3'd3, 1'b1, 8'd1, 16'd1, 8'h11}) begin
      tests_failed++; $display("FAIL mid_setup: state=%0d sel=%b pc=%0d instret=%0d ir=%0h want 3/1/1/1/11",
                               state, mem_addr_sel, pc, instret, ir);
    end
    reset = 1'b1;
    step(); #1;
    tests_run++;
    if ({state, pc, ir, instret, fault, mem_addr_sel, reg_we} !== {3'd0, 8'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL mid_reset: state=%0d pc=%0d ir=%0h instret=%0d fault=%b sel=%b we=%b want all 0",
                               state, pc, ir, instret, fault, mem_addr_sel, reg_we);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_li();
    test_ld();
    test_st();
    test_timeout();
    test_wrap_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
